// File: rtl/md_sequencer.sv
// md_sequencer: iterative multiply/divide unit beside the EX stage.
// Executes mult/multu/div/divu one bit per cycle on a shared 2W-bit shift
// datapath, stalls EX via busy, and returns {HI, LO} over a valid/ready
// handshake. cancel aborts whatever is in flight.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   req_valid/req_ready    operation request handshake (ready only in IDLE)
//   req_div, req_signed    operation select: divide/multiply, signed/unsigned
//   req_src1, req_src2     rs (dividend / multiplicand), rt (divisor / multiplier)
//   cancel                 pipeline flush, returns to IDLE on the next edge
//   busy                   operation in progress (CALC or FIX)
//   res_valid/res_ready    result handshake
//   res_hi, res_lo         remainder/quotient or product[2W-1:W]/[W-1:0]
module md_sequencer #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_div,
   input  logic         req_signed,
   input  logic [W-1:0] req_src1,
   input  logic [W-1:0] req_src2,
   input  logic         cancel,
   output logic         busy,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_hi,
   output logic [W-1:0] res_lo
);

   localparam int unsigned CW = $clog2(W) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             div_q, div_d;
   logic             sign1_q, sign1_d;
   logic             sign2_q, sign2_d;
   logic             dz_q, dz_d;
   logic [W-1:0]     opb_q, opb_d;    // divisor magnitude or multiplicand magnitude
   logic [2*W-1:0]   acc_q, acc_d;    // {rem, quo} for divide, {hi, lo} for multiply
   logic [W-1:0]     hi_q, hi_d;
   logic [W-1:0]     lo_q, lo_d;

   logic             accept;
   logic             s1, s2;
   logic [W-1:0]     mag1, mag2;
   logic [W:0]       partial, diff, sum;
   logic [2*W-1:0]   prod;

   assign accept = (state_q == S_IDLE) && req_valid && !cancel;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (req_valid)                state_d = S_CALC;
         S_CALC: if (cnt_q == CW'(W - 1))      state_d = S_FIX;
         S_FIX:                                state_d = S_DONE;
         S_DONE: if (res_ready)                state_d = S_IDLE;
         default:                              state_d = S_IDLE;
      endcase
      if (cancel) state_d = S_IDLE;
   end

   // Outputs
   always_comb begin
      req_ready = (state_q == S_IDLE);
      busy      = (state_q == S_CALC) || (state_q == S_FIX);
      res_valid = (state_q == S_DONE);
      res_hi    = hi_q;
      res_lo    = lo_q;
   end

   // Datapath
   always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      sign1_d = sign1_q;
      sign2_d = sign2_q;
      dz_d    = dz_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      s1   = req_src1[W-1] & req_signed;
      s2   = req_src2[W-1] & req_signed;
      mag1 = s1 ? -req_src1 : req_src1;
      mag2 = s2 ? -req_src2 : req_src2;

      // Restoring-divide trial: {rem, quo} shifted left, divisor taken off the top.
      partial = {acc_q[2*W-1:W], acc_q[W-1]};
      diff    = partial - {1'b0, opb_q};
      // Shift-add multiply: conditional add into the high half, carry kept for the shift.
      sum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      prod    = (sign1_q ^ sign2_q) ? -acc_q : acc_q;

      if (accept) begin
         cnt_d   = '0;
         div_d   = req_div;
         sign1_d = s1;
         sign2_d = s2;
         dz_d    = req_div && (req_src2 == '0);
         opb_d   = req_div ? mag2 : mag1;
         acc_d   = req_div ? {{W{1'b0}}, mag1} : {{W{1'b0}}, mag2};
      end else if (state_q == S_CALC) begin
         cnt_d = cnt_q + CW'(1);
         if (div_q) begin
            if (!diff[W]) acc_d = {diff[W-1:0],    acc_q[W-2:0], 1'b1};
            else          acc_d = {partial[W-1:0], acc_q[W-2:0], 1'b0};
         end else begin
            acc_d = {sum, acc_q[W-1:1]};
         end
      end else if ((state_q == S_FIX) && !cancel) begin
         if (div_q) begin
            // With a zero divisor every trial succeeds, so the remainder ends up
            // as the dividend magnitude; negating it by sign1 restores the
            // original dividend, and the all-ones quotient skips correction.
            hi_d = sign1_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
            if (dz_q)                    lo_d = '1;
            else if (sign1_q ^ sign2_q)  lo_d = -acc_q[W-1:0];
            else                         lo_d = acc_q[W-1:0];
         end else begin
            hi_d = prod[2*W-1:W];
            lo_d = prod[W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         div_q   <= 1'b0;
         sign1_q <= 1'b0;
         sign2_q <= 1'b0;
         dz_q    <= 1'b0;
         opb_q   <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         sign1_q <= sign1_d;
         sign2_q <= sign2_d;
         dz_q    <= dz_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_div = 1'b0;
   logic        req_signed = 1'b0;
   logic [31:0] req_src1 = '0;
   logic [31:0] req_src2 = '0;
   logic        cancel = 1'b0;
   logic        res_ready = 1'b0;
   logic        req_ready, busy, res_valid;
   logic [31:0] res_hi, res_lo;

   md_sequencer #(.W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_div    (req_div),
      .req_signed (req_signed),
      .req_src1   (req_src1),
      .req_src2   (req_src2),
      .cancel     (cancel),
      .busy       (busy),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_hi     (res_hi),
      .res_lo     (res_lo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Architectural result of an operation: {HI, LO}.
   function automatic logic [63:0] ref_res(input logic d, input logic s,
                                           input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] ua, ub;
      if (!d) begin
         if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
         end
         ua = {32'b0, a};
         ub = {32'b0, b};
         return ua * ub;
      end
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (s) begin
         sa = $signed(a);
         sb = $signed(b);
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   // Cycle-level behavioural model: cycles remaining until result, result flag.
   int          m_left = 0;
   bit          m_valid = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] m_pend = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_left = 0; m_valid = 1'b0; m_hi = '0; m_lo = '0;
      end else if (cancel) begin
         m_left = 0; m_valid = 1'b0;
      end else if (m_valid) begin
         if (res_ready) m_valid = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_valid = 1'b1;
            {m_hi, m_lo} = m_pend;
         end
      end else if (req_valid) begin
         m_left = 33;
         m_pend = ref_res(req_div, req_signed, req_src1, req_src2);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", req_ready, (m_left == 0) && !m_valid);
         chk("busy",      busy,      m_left > 0);
         chk("res_valid", res_valid, m_valid);
         chk("res_hi",    res_hi,    m_hi);
         chk("res_lo",    res_lo,    m_lo);
      end
   end

   task automatic issue(input logic d, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int e0);
      int n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      chk("ready_wait", req_ready, 1'b1);
      @(posedge clk); #2;
      req_valid = 1'b1; req_div = d; req_signed = s; req_src1 = a; req_src2 = b;
      @(posedge clk); #2;
      req_valid = 1'b0;
      e0 = cyc;
   endtask

   // mode 0: plain handshake; 1: stall 5 cycles first; 2: cancel alongside res_ready
   task automatic wait_result(input string name, input int e0, input logic [31:0] eh,
                              input logic [31:0] el, input int mode, input bit chk_busy);
      int bcnt = 0;
      bit got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (res_valid) got = 1'b1;
         else if (busy) bcnt++;
      end
      chk({name, " latency"}, got ? cyc - e0 : -1, 33);
      if (chk_busy) chk({name, " busy_cycles"}, bcnt, 33);
      chk({name, " hi"}, res_hi, eh);
      chk({name, " lo"}, res_lo, el);
      if (mode == 1) begin
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk({name, " hold valid"}, res_valid, 1'b1);
            chk({name, " hold ready"}, req_ready, 1'b0);
            chk({name, " hold hi"},    res_hi,    eh);
            chk({name, " hold lo"},    res_lo,    el);
         end
      end
      if (mode == 2) cancel = 1'b1;
      res_ready = 1'b1;
      @(posedge clk); #2;
      res_ready = 1'b0;
      cancel = 1'b0;
      @(negedge clk);
      chk({name, " valid_drop"}, res_valid, 1'b0);
      chk({name, " idle"},       req_ready, 1'b1);
      chk({name, " kept_lo"},    res_lo,    el);
   endtask

   task automatic run_op(input string name, input logic d, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int mode);
      int e0;
      issue(d, s, a, b, e0);
      wait_result(name, e0, eh, el, mode, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      #1;
      chk("rst req_ready", req_ready, 1'b1);
      chk("rst busy",      busy,      1'b0);
      chk("rst res_valid", res_valid, 1'b0);
      chk("rst res_hi",    res_hi,    32'd0);
      chk("rst res_lo",    res_lo,    32'd0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      chk_en = 1'b1;

      run_op("divu 100/7",  1, 0, 32'd100,        32'd7,          32'd2,          32'd14,         0);
      run_op("div -7/2",    1, 1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  0);
      run_op("div min/-1",  1, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  0);
      run_op("mult -1*-1",  0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1,          0);
      run_op("multu max",   0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          0);
      run_op("divu 5/0",    1, 0, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  0);
      run_op("div -5/0",    1, 1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFF,  0);
      run_op("divu 3/10",   1, 0, 32'd3,          32'd10,         32'd3,          32'd0,          0);
      run_op("div 7/-2",    1, 1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  2);
      run_op("mult x*-2",   0, 1, 32'h1234_5678,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hDB97_5310,  1);

      // cancel together with a request in IDLE: nothing is accepted
      @(posedge clk); #2;
      req_valid = 1'b1; req_div = 1'b0; req_signed = 1'b0; req_src1 = 32'd9; req_src2 = 32'd9;
      cancel = 1'b1;
      @(posedge clk); #2;
      req_valid = 1'b0; cancel = 1'b0;
      @(negedge clk);
      chk("idle cancel busy",  busy,      1'b0);
      chk("idle cancel ready", req_ready, 1'b1);

      // cancel at CALC iteration 10, new request on the very next cycle
      issue(1, 0, 32'd1000, 32'd3, e0);
      repeat (9) @(posedge clk);
      #2 cancel = 1'b1;
      @(posedge clk); #2;
      cancel = 1'b0;
      req_valid = 1'b1; req_div = 1'b0; req_signed = 1'b0; req_src1 = 32'd3; req_src2 = 32'd4;
      @(negedge clk);
      chk("cancel busy",  busy,      1'b0);
      chk("cancel ready", req_ready, 1'b1);
      @(posedge clk); #2;
      req_valid = 1'b0;
      e0 = cyc;
      wait_result("multu 3*4", e0, 32'd0, 32'd12, 0, 1'b1);

      // asynchronous reset in the middle of CALC
      issue(0, 0, 32'd77, 32'd5, e0);
      repeat (12) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("midrst req_ready", req_ready, 1'b1);
      chk("midrst busy",      busy,      1'b0);
      chk("midrst res_valid", res_valid, 1'b0);
      chk("midrst res_hi",    res_hi,    32'd0);
      chk("midrst res_lo",    res_lo,    32'd0);
      @(posedge clk); #2;
      reset = 1'b0;

      run_op("divu 9/3",    1, 0, 32'd9,          32'd3,          32'd0,          32'd3,          0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
